// File: rtl/fp_mul_div_pkg.sv
// rtl/fp_mul_div_pkg.sv - shared types and constants for the single-precision multiply/divide unit
package fp_mul_div_pkg;
    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int SIG_W = MAN_W + 1;
    localparam int BIAS  = 127;

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF = 32'h7F80_0000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_UNPACK,
        S_CALC,
        S_ROUND,
        S_DONE
    } state_t;

    typedef struct packed {
        logic io;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } flags_t;
endpackage

// File: rtl/fp_div_iter.sv
// rtl/fp_div_iter.sv - radix-2 restoring significand divider, one quotient bit per cycle
module fp_div_iter
    import fp_mul_div_pkg::*;
#(
    parameter int DIV_ITERS = 26
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             start,
    input  logic [SIG_W-1:0] dividend,
    input  logic [SIG_W-1:0] divisor,
    output logic [SIG_W+1:0] quotient,
    output logic             sticky,
    output logic             done
);
    localparam int CNT_W = $clog2(DIV_ITERS + 1);

    logic [SIG_W:0]   rem;
    logic [SIG_W:0]   diff;
    logic [SIG_W-1:0] dvs;
    logic [SIG_W+1:0] q;
    logic [CNT_W-1:0] cnt;
    logic             running;
    logic             ge;

    always_comb begin
        ge   = (rem >= {1'b0, dvs});
        diff = ge ? (rem - {1'b0, dvs}) : rem;
    end

    // A dividend smaller than the divisor is pre-doubled so the first quotient bit is always 1
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            rem     <= '0;
            dvs     <= '0;
            q       <= '0;
            cnt     <= '0;
            running <= 1'b0;
        end else if (start) begin
            rem     <= (dividend < divisor) ? {dividend, 1'b0} : {1'b0, dividend};
            dvs     <= divisor;
            q       <= '0;
            cnt     <= '0;
            running <= 1'b1;
        end else if (running) begin
            rem <= diff << 1;
            q   <= {q[SIG_W:0], ge};
            cnt <= cnt + 1'b1;
            if (cnt == CNT_W'(DIV_ITERS - 1)) running <= 1'b0;
        end
    end

    assign quotient = q;
    assign sticky   = |rem;
    assign done     = running && (cnt == CNT_W'(DIV_ITERS - 1));
endmodule

// File: rtl/fp_mul_div.sv
// rtl/fp_mul_div.sv - fixed-latency IEEE-754 single-precision multiply/divide with RNE rounding
module fp_mul_div
    import fp_mul_div_pkg::*;
#(
    parameter int DIV_ITERS = 26
) (
    input  logic        clk,
    input  logic        arst,
    input  logic        en,
    input  logic        sel,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] R,
    output logic        io_flag,
    output logic        dz_flag,
    output logic        of_flag,
    output logic        uf_flag,
    output logic        i_flag
);
    localparam logic signed [9:0] BIAS_S = 10'(BIAS);

    state_t state, state_nxt;
    logic [31:0] cap_a, cap_b;
    logic        cap_sel;

    logic [EXP_W-1:0] ea, eb;
    logic [SIG_W-1:0] ma, mb;
    logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, res_sign, div_pre;
    logic signed [9:0] ea_s, eb_s, exp_unp;

    assign ea       = cap_a[MAN_W+EXP_W-1:MAN_W];
    assign eb       = cap_b[MAN_W+EXP_W-1:MAN_W];
    assign ma       = {1'b1, cap_a[MAN_W-1:0]};
    assign mb       = {1'b1, cap_b[MAN_W-1:0]};
    assign a_zero   = (ea == '0);
    assign b_zero   = (eb == '0);
    assign a_inf    = (ea == '1) && (cap_a[MAN_W-1:0] == '0);
    assign b_inf    = (eb == '1) && (cap_b[MAN_W-1:0] == '0);
    assign a_nan    = (ea == '1) && (cap_a[MAN_W-1:0] != '0);
    assign b_nan    = (eb == '1) && (cap_b[MAN_W-1:0] != '0);
    assign res_sign = cap_a[31] ^ cap_b[31];
    assign div_pre  = (ma < mb);
    assign ea_s     = signed'({2'b00, ea});
    assign eb_s     = signed'({2'b00, eb});
    assign exp_unp  = cap_sel ? (ea_s - eb_s + BIAS_S - signed'({9'd0, div_pre}))
                              : (ea_s + eb_s - BIAS_S);

    logic        spec_hit, spec_io, spec_dz;
    logic [31:0] spec_val;

    // Special operands resolve during UNPACK but still ride the normal pipeline for fixed latency
    always_comb begin
        spec_hit = 1'b1;
        spec_val = {res_sign, 31'd0};
        spec_io  = 1'b0;
        spec_dz  = 1'b0;
        if (a_nan || b_nan) begin
            spec_val = QNAN;
            spec_io  = 1'b1;
        end else if (!cap_sel) begin
            if ((a_zero && b_inf) || (a_inf && b_zero)) begin
                spec_val = QNAN;
                spec_io  = 1'b1;
            end else if (a_inf || b_inf) begin
                spec_val = {res_sign, POS_INF[30:0]};
            end else if (!(a_zero || b_zero)) begin
                spec_hit = 1'b0;
            end
        end else begin
            if ((a_zero && b_zero) || (a_inf && b_inf)) begin
                spec_val = QNAN;
                spec_io  = 1'b1;
            end else if (a_inf) begin
                spec_val = {res_sign, POS_INF[30:0]};
            end else if (b_zero && !a_zero) begin
                spec_val = {res_sign, POS_INF[30:0]};
                spec_dz  = 1'b1;
            end else if (!(b_inf || a_zero)) begin
                spec_hit = 1'b0;
            end
        end
    end

    logic              r_sign, r_spec_hit, r_spec_io, r_spec_dz;
    logic [31:0]       r_spec_val;
    logic signed [9:0] r_exp;
    logic [SIG_W-1:0]  r_ma, r_mb;
    logic [47:0]       prod;
    logic [SIG_W+1:0]  quot;
    logic              div_sticky, div_done;

    fp_div_iter #(.DIV_ITERS(DIV_ITERS)) u_div (
        .clk      (clk),
        .arst     (arst),
        .start    ((state == S_UNPACK) && cap_sel),
        .dividend (ma),
        .divisor  (mb),
        .quotient (quot),
        .sticky   (div_sticky),
        .done     (div_done)
    );

    logic [SIG_W-1:0]  m24;
    logic              g_bit, r_bit, s_bit, rnd_up;
    logic signed [9:0] e_pre, e_fin;
    logic [SIG_W:0]    m_sum;
    logic [MAN_W-1:0]  m_fin;
    logic [31:0]       res_r;
    flags_t            res_f, flg;

    always_comb begin
        m24   = prod[46:23];
        g_bit = prod[22];
        r_bit = prod[21];
        s_bit = |prod[20:0];
        e_pre = r_exp;
        if (cap_sel) begin
            m24   = quot[SIG_W+1:2];
            g_bit = quot[1];
            r_bit = quot[0];
            s_bit = div_sticky;
        end else if (prod[47]) begin
            m24   = prod[47:24];
            g_bit = prod[23];
            r_bit = prod[22];
            s_bit = |prod[21:0];
            e_pre = r_exp + 10'sd1;
        end
        rnd_up = g_bit & (r_bit | s_bit | m24[0]);
        m_sum  = {1'b0, m24} + {{SIG_W{1'b0}}, rnd_up};
        if (m_sum[SIG_W]) begin
            e_fin = e_pre + 10'sd1;
            m_fin = m_sum[MAN_W:1];
        end else begin
            e_fin = e_pre;
            m_fin = m_sum[MAN_W-1:0];
        end
        res_f = '0;
        if (r_spec_hit) begin
            res_r    = r_spec_val;
            res_f.io = r_spec_io;
            res_f.dz = r_spec_dz;
        end else if (e_fin >= 10'sd255) begin
            res_r    = {r_sign, POS_INF[30:0]};
            res_f.of = 1'b1;
            res_f.nx = 1'b1;
        end else if (e_fin <= 10'sd0) begin
            res_r    = {r_sign, 31'd0};
            res_f.uf = 1'b1;
            res_f.nx = 1'b1;
        end else begin
            res_r    = {r_sign, e_fin[EXP_W-1:0], m_fin};
            res_f.nx = g_bit | r_bit | s_bit;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (en) state_nxt = S_UNPACK;
            S_UNPACK: state_nxt = S_CALC;
            S_CALC:   if (!cap_sel || div_done) state_nxt = S_ROUND;
            S_ROUND:  state_nxt = S_DONE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state      <= S_IDLE;
            cap_a      <= '0;
            cap_b      <= '0;
            cap_sel    <= 1'b0;
            r_sign     <= 1'b0;
            r_exp      <= '0;
            r_ma       <= '0;
            r_mb       <= '0;
            r_spec_hit <= 1'b0;
            r_spec_val <= '0;
            r_spec_io  <= 1'b0;
            r_spec_dz  <= 1'b0;
            prod       <= '0;
            R          <= '0;
            flg        <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && en) begin
                cap_a   <= a;
                cap_b   <= b;
                cap_sel <= sel;
            end
            if (state == S_UNPACK) begin
                r_sign     <= res_sign;
                r_exp      <= exp_unp;
                r_ma       <= ma;
                r_mb       <= mb;
                r_spec_hit <= spec_hit;
                r_spec_val <= spec_val;
                r_spec_io  <= spec_io;
                r_spec_dz  <= spec_dz;
            end
            if (state == S_CALC) prod <= {24'd0, r_ma} * {24'd0, r_mb};
            if (state == S_ROUND) begin
                R   <= res_r;
                flg <= res_f;
            end
        end
    end

    assign busy    = (state != S_IDLE);
    assign done    = (state == S_DONE);
    assign io_flag = flg.io;
    assign dz_flag = flg.dz;
    assign of_flag = flg.of;
    assign uf_flag = flg.uf;
    assign i_flag  = flg.nx;
endmodule

// File: tb/tb_fp_mul_div.sv
// tb/tb_fp_mul_div.sv - self-checking bench for fp_mul_div against an arithmetic reference model
module tb_fp_mul_div;
    logic        clk = 1'b0;
    logic        arst, en, sel;
    logic [31:0] a, b;
    logic        busy, done;
    logic [31:0] R;
    logic        io_flag, dz_flag, of_flag, uf_flag, i_flag;

    int checks = 0;
    int errors = 0;

    fp_mul_div #(.DIV_ITERS(26)) dut (
        .clk     (clk),
        .arst    (arst),
        .en      (en),
        .sel     (sel),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .R       (R),
        .io_flag (io_flag),
        .dz_flag (dz_flag),
        .of_flag (of_flag),
        .uf_flag (uf_flag),
        .i_flag  (i_flag)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] flags_now();
        return {27'd0, io_flag, dz_flag, of_flag, uf_flag, i_flag};
    endfunction

    // Flags packed as {io, dz, of, uf, inexact}; result computed from exact integer arithmetic
    function automatic void ref_model(input logic s, input logic [31:0] x, input logic [31:0] y,
                                      output logic [31:0] r, output logic [4:0] f);
        int ea, eb, p, sh, k, e;
        longint unsigned mx, my, num, rem, half, sig;
        logic sgn, st, xz, yz, xi, yi, xn, yn, inexact;
        ea  = int'(x[30:23]);
        eb  = int'(y[30:23]);
        xz  = (ea == 0);
        yz  = (eb == 0);
        xi  = (ea == 255) && (x[22:0] == 0);
        yi  = (eb == 255) && (y[22:0] == 0);
        xn  = (ea == 255) && (x[22:0] != 0);
        yn  = (eb == 255) && (y[22:0] != 0);
        sgn = x[31] ^ y[31];
        f   = 5'b0;
        r   = 32'h0;
        mx  = 64'(x[22:0]) | 64'h80_0000;
        my  = 64'(y[22:0]) | 64'h80_0000;
        if (xn || yn) begin r = 32'h7FC0_0000; f = 5'b10000; return; end
        if (!s) begin
            if ((xz && yi) || (xi && yz)) begin r = 32'h7FC0_0000; f = 5'b10000; return; end
            if (xi || yi) begin r = {sgn, 31'h7F80_0000}; return; end
            if (xz || yz) begin r = {sgn, 31'h0}; return; end
            num = mx * my;
            st  = 1'b0;
            k   = (ea - 127) + (eb - 127) - 46;
        end else begin
            if ((xz && yz) || (xi && yi)) begin r = 32'h7FC0_0000; f = 5'b10000; return; end
            if (xi) begin r = {sgn, 31'h7F80_0000}; return; end
            if (yi) begin r = {sgn, 31'h0}; return; end
            if (yz) begin r = {sgn, 31'h7F80_0000}; f = 5'b01000; return; end
            if (xz) begin r = {sgn, 31'h0}; return; end
            num = (mx << 40) / my;
            st  = ((mx << 40) % my) != 0;
            k   = (ea - 127) - (eb - 127) - 40;
        end
        p = 63;
        while (p > 0 && num[p] == 1'b0) p--;
        sh      = p - 23;
        sig     = num >> sh;
        rem     = num & ((64'd1 << sh) - 64'd1);
        half    = 64'd1 << (sh - 1);
        e       = p + k + 127;
        inexact = (rem != 0) || st;
        if (rem > half || (rem == half && (st || sig[0]))) sig++;
        if (sig == (64'd1 << 24)) begin sig = sig >> 1; e++; end
        if (e >= 255) begin
            r = {sgn, 31'h7F80_0000}; f = 5'b00101;
        end else if (e <= 0) begin
            r = {sgn, 31'h0}; f = 5'b00011;
        end else begin
            r = {sgn, 8'(e), sig[22:0]}; f = {4'b0, inexact};
        end
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [31:0] v;
        v = $urandom;
        case ($urandom_range(0, 11))
            0:       v[30:23] = 8'd0;
            1:       v[30:0]  = 31'h7F80_0000;
            2:       begin v[30:23] = 8'hFF; v[22] = 1'b1; end
            3:       v[30:23] = 8'($urandom_range(230, 254));
            4:       v[30:23] = 8'($urandom_range(1, 30));
            5:       v[30:23] = 8'd127;
            default: v[30:23] = 8'($urandom_range(1, 254));
        endcase
        return v;
    endfunction

    // Issues one op from IDLE, pokes en with junk while busy, checks latency/result, returns in IDLE
    task automatic run_op(input string tag, input logic s, input logic [31:0] av, input logic [31:0] bv,
                          input logic [31:0] er, input logic [4:0] ef);
        int cyc;
        en = 1'b1; sel = s; a = av; b = bv;
        @(posedge clk); #1;
        chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
        cyc = 0;
        while (!done && cyc < 40) begin
            en = 1'b1; sel = ~s; a = $urandom; b = $urandom;
            @(posedge clk); #1;
            cyc++;
        end
        en = 1'b0;
        chk({tag, "_lat"}, cyc, s ? 32'd28 : 32'd3);
        chk({tag, "_R"}, R, er);
        chk({tag, "_flags"}, flags_now(), {27'd0, ef});
        @(posedge clk); #1;
        chk({tag, "_idle"}, {30'd0, busy, done}, 32'd0);
        chk({tag, "_hold"}, R, er);
    endtask

    initial begin
        logic [31:0] er, av, bv;
        logic [4:0]  ef;
        logic        sv;
        int          pulses, k, captured, completed, busy_end, next_cap, lat;
        logic [31:0] q_r[$];
        logic [4:0]  q_f[$];

        arst = 1'b0; en = 1'b0; sel = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy_done", {30'd0, busy, done}, 32'd0);
        chk("reset_R", R, 32'd0);
        chk("reset_flags", flags_now(), 32'd0);
        arst = 1'b1;
        @(posedge clk); #1;

        run_op("mul_2x3",    1'b0, 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 5'b00000);
        run_op("div_1by3",   1'b1, 32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB, 5'b00001);
        run_op("div_by0",    1'b1, 32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 5'b01000);
        run_op("mul_0xinf",  1'b0, 32'h0000_0000, 32'h7F80_0000, 32'h7FC0_0000, 5'b10000);
        run_op("mul_ovf",    1'b0, 32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, 5'b00101);
        run_op("mul_unf",    1'b0, 32'h0080_0000, 32'h0080_0000, 32'h0000_0000, 5'b00011);
        run_op("div_0by0",   1'b1, 32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 5'b10000);
        run_op("div_infinf", 1'b1, 32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, 5'b10000);
        run_op("div_fininf", 1'b1, 32'hBF80_0000, 32'h7F80_0000, 32'h8000_0000, 5'b00000);
        run_op("div_inffin", 1'b1, 32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, 5'b00000);
        run_op("mul_neg",    1'b0, 32'hC000_0000, 32'h4040_0000, 32'hC0C0_0000, 5'b00000);
        run_op("mul_rnddn",  1'b0, 32'h3F80_0001, 32'h3F7F_FFFF, 32'h3F80_0000, 5'b00001);
        run_op("mul_subn",   1'b0, 32'h8000_0001, 32'h3F80_0000, 32'h8000_0000, 5'b00000);
        run_op("mul_nan",    1'b0, 32'h7F80_0001, 32'h3F80_0000, 32'h7FC0_0000, 5'b10000);

        en = 1'b1; sel = 1'b1; a = 32'h3F80_0000; b = 32'h4040_0000;
        @(posedge clk); #1;
        en = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        arst = 1'b0;
        #1;
        chk("abort_busy_done", {30'd0, busy, done}, 32'd0);
        chk("abort_R", R, 32'd0);
        chk("abort_flags", flags_now(), 32'd0);
        pulses = 0;
        repeat (2) begin @(posedge clk); #1; pulses += int'(done); end
        arst = 1'b1;
        repeat (30) begin @(posedge clk); #1; pulses += int'(done) + int'(busy); end
        chk("abort_no_done", pulses, 32'd0);
        run_op("post_abort_mul", 1'b0, 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 5'b00000);

        for (int i = 0; i < 40; i++) begin
            sv = 1'($urandom_range(0, 1));
            av = rand_fp();
            bv = rand_fp();
            ref_model(sv, av, bv, er, ef);
            run_op(sv ? "rnd_div" : "rnd_mul", sv, av, bv, er, ef);
        end

        k = 0; captured = 0; completed = 0; busy_end = -1; next_cap = 0;
        while (completed < 100 && k < 6000) begin
            sv = 1'($urandom_range(0, 1));
            av = rand_fp();
            bv = rand_fp();
            en = (captured < 100); sel = sv; a = av; b = bv;
            if (en && k == next_cap) begin
                ref_model(sv, av, bv, er, ef);
                q_r.push_back(er);
                q_f.push_back(ef);
                lat      = sv ? 28 : 3;
                busy_end = k + lat;
                next_cap = k + lat + 2;
                captured++;
            end
            @(posedge clk); #1;
            chk("strm_busy", {31'd0, busy}, {31'd0, k <= busy_end});
            chk("strm_done", {31'd0, done}, {31'd0, k == busy_end});
            if (k == busy_end) begin
                chk("strm_R", R, q_r.pop_front());
                chk("strm_flags", flags_now(), {27'd0, q_f.pop_front()});
                completed++;
            end
            k++;
        end
        en = 1'b0;
        chk("strm_completed", completed, 32'd100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
